// File: rtl/imem_loader_pkg.sv
// Shared constants, FSM state encoding and checksum rule for the instruction-memory loader.
package imem_loader_pkg;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  // Image is valid when all program bytes plus the checksum byte sum to zero mod 2**DW.
  function automatic logic checksum_ok(input logic [DW-1:0] sum, input logic [DW-1:0] chk);
    logic [DW-1:0] total;
    total = sum + chk;
    return total == '0;
  endfunction

endpackage

// File: rtl/imem_ram8x8.sv
// Small instruction store: one synchronous write port, one combinational read port, async clear.
module imem_ram8x8 #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Read sees the pre-edge contents, so a same-cycle write is visible only next cycle.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into instruction RAM, verifies its checksum and releases the CPU.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_data,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW:0]   count
);

  state_t        state_reg;
  logic [AW-1:0] ptr_reg;
  logic [DW-1:0] sum_reg;
  logic [AW:0]   count_reg;
  logic          ram_we;

  // Only program bytes reach memory; the checksum byte in CHECK is never stored.
  assign ram_we = (state_reg == S_LOAD) && in_valid;

  imem_ram8x8 #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (CLK),
    .rst_n (RST),
    .we    (ram_we),
    .waddr (ptr_reg),
    .wdata (in_data),
    .raddr (fetch_addr),
    .rdata (fetch_data)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      sum_reg   <= '0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_reg <= S_LOAD;
            ptr_reg   <= '0;
            sum_reg   <= '0;
            count_reg <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            ptr_reg   <= ptr_reg + 1'b1;
            sum_reg   <= sum_reg + in_data;
            count_reg <= count_reg + 1'b1;
            if (ptr_reg == AW'(DEPTH - 1)) begin
              state_reg <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (in_valid) begin
            state_reg <= checksum_ok(sum_reg, in_data) ? S_DONE : S_ERROR;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (state_reg == S_LOAD) || (state_reg == S_CHECK);
  assign busy     = in_ready;
  assign done     = (state_reg == S_DONE);
  assign error    = (state_reg == S_ERROR);
  assign cpu_hold = (state_reg != S_DONE);
  assign count    = count_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed vector table, corner sequences, randomized run vs. a queue-based model.
`timescale 1ns/1ps
module tb_imem_loader;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [2:0] fetch_addr = 3'd0;
  logic [7:0] fetch_data;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  imem_loader dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .count      (count)
  );

  always #10 CLK = ~CLK;

  // Reference model: the accepted program bytes form a queue; the image's fate is decided
  // by the byte that arrives once the queue already holds 8 entries.
  bit         m_active;
  bit         m_good;
  bit         m_bad;
  logic [7:0] m_q[$];
  logic [7:0] m_mem[8];

  function automatic logic [7:0] q_sum();
    logic [7:0] s = 8'h00;
    foreach (m_q[i]) s += m_q[i];
    return s;
  endfunction

  task automatic model_reset();
    m_active = 0; m_good = 0; m_bad = 0;
    m_q.delete();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
  endtask

  task automatic model_step(input logic s, input logic v, input logic [7:0] d);
    logic [7:0] total;
    if (m_active) begin
      if (v) begin
        if (m_q.size() < 8) begin
          m_mem[m_q.size()] = d;
          m_q.push_back(d);
        end else begin
          total    = q_sum() + d;
          m_good   = (total == 8'h00);
          m_bad    = !m_good;
          m_active = 0;
        end
      end
    end else if (s) begin
      m_active = 1; m_good = 0; m_bad = 0;
      m_q.delete();
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic fetch_expect(input int addr, input logic [7:0] exp);
    fetch_addr = 3'(addr);
    #1;
    chk($sformatf("fetch[%0d]", addr), fetch_data, exp);
  endtask

  task automatic check_all(input string tag);
    int a;
    chk({tag, ".count"},    count,    m_q.size());
    chk({tag, ".busy"},     busy,     m_active);
    chk({tag, ".in_ready"}, in_ready, m_active);
    chk({tag, ".done"},     done,     m_good);
    chk({tag, ".error"},    error,    m_bad);
    chk({tag, ".cpu_hold"}, cpu_hold, !m_good);
    a = $urandom_range(0, 7);
    fetch_expect(a, m_mem[a]);
  endtask

  // One clock: drive inputs, step the model at the edge, compare shortly after.
  task automatic cycle(input logic s, input logic v, input logic [7:0] d);
    start = s; in_valid = v; in_data = d;
    @(posedge CLK);
    model_step(s, v, d);
    #1;
    start = 0; in_valid = 0;
    $display("cyc t=%0t start=%0b valid=%0b data=%02h -> count=%0d busy=%0b done=%0b error=%0b hold=%0b",
             $time, s, v, d, count, busy, done, error, cpu_hold);
    check_all("cyc");
  endtask

  task automatic do_reset();
    RST = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    for (int i = 0; i < 8; i++) fetch_expect(i, 8'h00);
    @(negedge CLK);
    RST = 1'b1;
    cycle(0, 0, 8'h00);
  endtask

  typedef struct {
    logic       s;
    logic       v;
    logic [7:0] d;
    int         cnt;
    logic       busy;
    logic       done;
    logic       hold;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Scenario 2 vectors: start, bytes 1..8, checksum 0xDC.
    tbl[0] = '{1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1};
    for (int i = 1; i <= 8; i++) tbl[i] = '{1'b0, 1'b1, 8'(i), i, 1'b1, 1'b0, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 8'hDC, 8, 1'b0, 1'b1, 1'b0};

    model_reset();
    @(posedge CLK); #1;
    do_reset();
    chk("rst.count", count, 0);
    chk("rst.hold", cpu_hold, 1);
    chk("rst.in_ready", in_ready, 0);

    // Good load from the table.
    foreach (tbl[i]) begin
      cycle(tbl[i].s, tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d.count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d.busy", i),  busy,  tbl[i].busy);
      chk($sformatf("tbl%0d.done", i),  done,  tbl[i].done);
      chk($sformatf("tbl%0d.hold", i),  cpu_hold, tbl[i].hold);
    end
    fetch_expect(5, 8'h06);
    fetch_expect(7, 8'h08);

    // Bad checksum, then restart clears the error.
    cycle(1, 0, 8'h00);
    for (int i = 1; i <= 8; i++) cycle(0, 1, 8'(i));
    cycle(0, 1, 8'h00);
    chk("bad.error", error, 1);
    chk("bad.done", done, 0);
    chk("bad.hold", cpu_hold, 1);
    chk("bad.in_ready", in_ready, 0);
    cycle(1, 0, 8'h00);
    chk("restart.error", error, 0);
    chk("restart.busy", busy, 1);
    chk("restart.count", count, 0);

    // Gapped stream of 1..8 with in_valid pattern 1,0,0,1,...
    begin
      int b = 1;
      int k = 0;
      while (b <= 8) begin
        if (k % 3 == 0) begin
          cycle(0, 1, 8'(b));
          chk("gap.count", count, b);
          b++;
        end else begin
          cycle(0, 0, 8'hFF);
          chk("gap.hold_count", count, b - 1);
        end
        k++;
      end
    end
    cycle(0, 1, 8'hDC);
    chk("gap.done", done, 1);
    for (int i = 0; i < 8; i++) fetch_expect(i, 8'(i + 1));

    // Restart from DONE; start during LOAD ignored; reload 0xA0..0xA7 + 0xE4.
    cycle(1, 0, 8'h00);
    chk("reld.hold", cpu_hold, 1);
    chk("reld.busy", busy, 1);
    fetch_expect(0, 8'h01);
    start = 0; in_valid = 1; in_data = 8'hA0;
    #1;
    chk("same_cycle_old", fetch_data, 8'h01);
    cycle(0, 1, 8'hA0);
    fetch_expect(0, 8'hA0);
    for (int i = 1; i < 8; i++) begin
      cycle(i == 3, 1, 8'hA0 + 8'(i));
      chk("reld.count", count, i + 1);
    end
    cycle(0, 1, 8'hE4);
    chk("reld.done", done, 1);
    fetch_expect(0, 8'hA0);

    // Reset mid-load after 4 bytes.
    cycle(1, 0, 8'h00);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h30 + 8'(i));
    chk("mid.count_pre", count, 4);
    do_reset();
    chk("mid.count", count, 0);
    chk("mid.hold", cpu_hold, 1);
    chk("mid.busy", busy, 0);

    // Randomized run against the model.
    for (int n = 0; n < 400; n++) begin
      logic s, v;
      logic [7:0] d;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        s = ($urandom_range(0, 7) == 0);
        v = $urandom_range(0, 1);
        d = 8'($urandom);
        if (m_active && m_q.size() == 8 && $urandom_range(0, 1)) d = 8'h00 - q_sum();
        cycle(s, v, d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
